// File: rtl/bnn_fmap_sequencer.sv
// Layer sequencer for the binary CNN datapath: drives the conv engines through
// two layers, buffers layer-1 bit maps per channel and majority-merges layer-2
// results into a serial stream for the fully-connected stage.
module bnn_fmap_sequencer #(
  parameter int CH        = 3,
  parameter int FMAP_BITS = 676,
  parameter int PIX_W     = 8,
  parameter int THRESH    = 127
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [PIX_W-1:0] pic_din,
  input  logic [CH-1:0]    conv_result,
  input  logic [CH-1:0]    conv_result_valid,
  input  logic             conv_rd,
  input  logic [CH-1:0]    conv_done,
  input  logic             fc_done,
  output logic [CH-1:0]    conv_din,
  output logic [CH-1:0]    conv_start,
  output logic             stage,
  output logic             fc_din,
  output logic             fc_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               PW         = $clog2(FMAP_BITS + 1);
  localparam logic [PW-1:0]    PTR_FULL   = PW'(FMAP_BITS);
  localparam logic [PW-1:0]    PTR_LAST   = PW'(FMAP_BITS - 1);
  localparam logic [PIX_W-1:0] PIX_THRESH = PIX_W'(THRESH);
  localparam logic [3:0]       HALF       = 4'(CH / 2);

  typedef enum logic [2:0] {IDLE, L1, L2, FCW, FIN} state_t;

  state_t               state_q;
  logic [PW-1:0]        wrPtr_q [CH];
  logic [PW-1:0]        rdPtr_q;
  logic [CH-1:0]        doneSeen_q;
  logic [CH-1:0]        convStart_q;
  logic                 fcDin_q;
  logic                 fcValid_q;
  logic                 done_q;
  logic                 err_q;
  logic [FMAP_BITS-1:0] fmap_q [CH];

  logic          pixBit;
  logic [3:0]    onesCount;
  logic          allValid;
  logic          anyValid;
  logic          allDone;
  logic [CH-1:0] wrEnable;
  logic [CH-1:0] wrOverflow;

  // Datapath decode: pixel binarisation, popcount for the vote, write qualifiers
  // and the per-channel input bit (buffer readback in layer 2, pixel otherwise).
  always_comb begin
    pixBit     = (pic_din > PIX_THRESH);
    allValid   = &conv_result_valid;
    anyValid   = |conv_result_valid;
    allDone    = &doneSeen_q;
    onesCount  = '0;
    wrEnable   = '0;
    wrOverflow = '0;
    conv_din   = '0;
    for (int i = 0; i < CH; i++) begin
      onesCount     = onesCount + 4'(conv_result[i]);
      wrEnable[i]   = (state_q == L1) && conv_result_valid[i] && (wrPtr_q[i] != PTR_FULL);
      wrOverflow[i] = (state_q == L1) && conv_result_valid[i] && (wrPtr_q[i] == PTR_FULL);
      conv_din[i]   = (state_q == L2) ? fmap_q[i][rdPtr_q] : pixBit;
    end
  end

  // Inference FSM with its pointers, completion tracking, merge and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rdPtr_q     <= '0;
      doneSeen_q  <= '0;
      convStart_q <= '0;
      fcDin_q     <= 1'b0;
      fcValid_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < CH; i++) wrPtr_q[i] <= '0;
    end else begin
      convStart_q <= '0;
      done_q      <= 1'b0;
      fcValid_q   <= 1'b0;
      doneSeen_q  <= doneSeen_q | conv_done;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= L1;
            convStart_q <= '1;
            err_q       <= 1'b0;
            rdPtr_q     <= '0;
            doneSeen_q  <= '0;
            for (int i = 0; i < CH; i++) wrPtr_q[i] <= '0;
          end
        end
        L1: begin
          for (int i = 0; i < CH; i++) begin
            if (wrEnable[i]) wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
          end
          if (|wrOverflow) err_q <= 1'b1;
          if (allDone) begin
            state_q     <= L2;
            convStart_q <= '1;
            doneSeen_q  <= '0;
          end
        end
        L2: begin
          if (conv_rd) begin
            if (rdPtr_q == PTR_LAST) err_q <= 1'b1;
            else rdPtr_q <= rdPtr_q + 1'b1;
          end
          if (allValid) begin
            fcValid_q <= 1'b1;
            fcDin_q   <= (onesCount > HALF);
          end else if (anyValid) begin
            err_q <= 1'b1;
          end
          if (allDone) state_q <= FCW;
        end
        FCW: begin
          if (fc_done) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-channel layer-1 feature map storage; read-only outside layer 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) fmap_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wrEnable[i]) fmap_q[i][wrPtr_q[i]] <= conv_result[i];
      end
    end
  end

  assign conv_start = convStart_q;
  assign stage      = (state_q == L2) || (state_q == FCW) || (state_q == FIN);
  assign busy       = (state_q != IDLE);
  assign fc_din     = fcDin_q;
  assign fc_valid   = fcValid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bnn_fmap_sequencer.sv
// Self-checking bench for bnn_fmap_sequencer: three inferences driven with
// random data and compared against a bit-map / vote reference model.
module tb_bnn_fmap_sequencer;

  localparam int CH = 3;
  localparam int FB = 676;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [7:0]    pic_din;
  logic [CH-1:0] conv_result;
  logic [CH-1:0] conv_result_valid;
  logic          conv_rd;
  logic [CH-1:0] conv_done;
  logic          fc_done;
  logic [CH-1:0] conv_din;
  logic [CH-1:0] conv_start;
  logic          stage;
  logic          fc_din;
  logic          fc_valid;
  logic          busy;
  logic          done;
  logic          err;

  int errorCount = 0;
  int checkCount = 0;

  bit model [CH][FB];
  int wcount [CH];

  bnn_fmap_sequencer #(.CH(CH), .FMAP_BITS(FB), .PIX_W(8), .THRESH(127)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pic_din(pic_din),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid),
    .conv_rd(conv_rd), .conv_done(conv_done), .fc_done(fc_done),
    .conv_din(conv_din), .conv_start(conv_start), .stage(stage),
    .fc_din(fc_din), .fc_valid(fc_valid), .busy(busy), .done(done), .err(err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the clock edge sample them, settle 1 unit after.
  task automatic applyStimulus(input logic s, input logic [CH-1:0] v, input logic [CH-1:0] r,
                               input logic rd, input logic [CH-1:0] cd, input logic fd);
    start             = s;
    conv_result_valid = v;
    conv_result       = r;
    conv_rd           = rd;
    conv_done         = cd;
    fc_done           = fd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH-1:0] modelBits(input int idx);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = model[c][idx];
    return v;
  endfunction

  function automatic logic majority(input logic [CH-1:0] r);
    return ($countones(r) > CH / 2);
  endfunction

  function automatic logic [CH-1:0] pixExpect(input logic [7:0] p);
    return (p > 8'd127) ? {CH{1'b1}} : {CH{1'b0}};
  endfunction

  initial begin
    logic [CH-1:0] v;
    logic [CH-1:0] r;
    logic [CH-1:0] cd;
    logic          expErr;
    int            guard;

    rstn = 1'b0; start = 0; pic_din = 0; conv_result = 0; conv_result_valid = 0;
    conv_rd = 0; conv_done = 0; fc_done = 0;
    #3;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_stage", stage, 0);
    checkOutput("rst_start", conv_start, 0);
    checkOutput("rst_fcvalid", fc_valid, 0);
    checkOutput("rst_fcdin", fc_din, 0);
    checkOutput("rst_done", done, 0);
    pic_din = 8'd200; #1 checkOutput("pix200", conv_din, 3'b111);
    pic_din = 8'd127; #1 checkOutput("pix127", conv_din, 3'b000);
    pic_din = 8'd128; #1 checkOutput("pix128", conv_din, 3'b111);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pic_din = 8'($urandom);
      #1 checkOutput("idle_pix", conv_din, pixExpect(pic_din));
    end

    // ---------------- inference A: alternating pattern ----------------
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("A_l1_stage", stage, 0);
    checkOutput("A_l1_busy", busy, 1);
    checkOutput("A_l1_cstart", conv_start, 3'b111);
    checkOutput("A_l1_err", err, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("A_cstart_off", conv_start, 3'b000);
    checkOutput("A_start_ign", stage, 0);
    for (int k = 0; k < FB; k++) begin
      for (int c = 0; c < CH; c++) model[c][k] = (k % 2 == 0);
      pic_din = 8'($urandom);
      applyStimulus(0, 3'b111, {CH{(k % 2 == 0) ? 1'b1 : 1'b0}}, 0, 0, 0);
      checkOutput("A_l1_pix", conv_din, pixExpect(pic_din));
    end
    checkOutput("A_wr_err", err, 0);
    applyStimulus(0, 0, 0, 0, 3'b100, 0);
    checkOutput("A_done2", stage, 0);
    applyStimulus(0, 0, 0, 0, 3'b001, 0);
    checkOutput("A_done0", stage, 0);
    applyStimulus(0, 0, 0, 0, 3'b010, 0);
    checkOutput("A_done1", stage, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A_l2_stage", stage, 1);
    checkOutput("A_l2_cstart", conv_start, 3'b111);
    checkOutput("A_rd0", conv_din, modelBits(0));
    for (int k = 0; k < 8; k++) begin
      r = (k == 0) ? 3'b011 : (k == 1) ? 3'b100 : 3'($urandom);
      applyStimulus(0, 3'b111, r, 0, 0, 0);
      if (k == 0) checkOutput("A_l2_cstart_off", conv_start, 3'b000);
      checkOutput("A_fcvalid", fc_valid, 1);
      checkOutput("A_fcdin", fc_din, majority(r));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A_fcvalid_off", fc_valid, 0);
    for (int k = 1; k < FB; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("A_readback", conv_din, modelBits(k));
    end
    checkOutput("A_rd_noerr", err, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("A_rd_hold", conv_din, modelBits(FB - 1));
    checkOutput("A_rd_ovf_err", err, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("A_rd_hold2", conv_din, modelBits(FB - 1));
    applyStimulus(0, 0, 0, 0, 3'b111, 0);
    checkOutput("A_l2_wait", stage, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("A_fcw_busy", busy, 1);
      checkOutput("A_fcw_done", done, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("A_fin_done", done, 1);
    checkOutput("A_fin_busy", busy, 1);
    checkOutput("A_fin_stage", stage, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("A_idle_done", done, 0);
    checkOutput("A_idle_busy", busy, 0);
    checkOutput("A_idle_stage", stage, 0);
    checkOutput("A_err_sticky", err, 1);

    // ---------------- inference B: random data, write overflow ----------------
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("B_err_clr", err, 0);
    checkOutput("B_cstart", conv_start, 3'b111);
    for (int c = 0; c < CH; c++) wcount[c] = 0;
    guard = 0;
    while ((wcount[0] < FB || wcount[1] < FB || wcount[2] < FB) && guard < 20000) begin
      v = '0; r = '0; cd = '0;
      for (int c = 0; c < CH; c++) begin
        if (wcount[c] < FB && ($urandom % 4 != 0)) begin
          v[c] = 1'b1;
          r[c] = 1'($urandom);
          model[c][wcount[c]] = r[c];
          wcount[c]++;
          if (c == 1 && wcount[c] == FB) cd[1] = 1'b1;
        end
      end
      applyStimulus(0, v, r, 0, cd, 0);
      guard++;
    end
    checkOutput("B_wr_guard", (guard < 20000), 1);
    checkOutput("B_wr_noerr", err, 0);
    checkOutput("B_still_l1", stage, 0);
    applyStimulus(0, 3'b001, 3'($urandom), 0, 0, 0);
    checkOutput("B_wr_ovf_err", err, 1);
    applyStimulus(0, 0, 0, 0, 3'b001, 0);
    checkOutput("B_done0", stage, 0);
    applyStimulus(0, 0, 0, 0, 3'b100, 0);
    checkOutput("B_done2", stage, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("B_l2_stage", stage, 1);
    checkOutput("B_rd0", conv_din, modelBits(0));
    for (int k = 1; k < FB; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("B_readback", conv_din, modelBits(k));
    end
    pic_din = 8'd10;
    #2 rstn = 1'b0;
    #1;
    checkOutput("B_arst_busy", busy, 0);
    checkOutput("B_arst_stage", stage, 0);
    checkOutput("B_arst_err", err, 0);
    checkOutput("B_arst_fcvalid", fc_valid, 0);
    checkOutput("B_arst_done", done, 0);
    checkOutput("B_arst_cstart", conv_start, 0);
    checkOutput("B_arst_din", conv_din, 3'b000);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < CH; c++) for (int k = 0; k < FB; k++) model[c][k] = 1'b0;

    // ---------------- inference C: cleared buffers and merge errors ----------------
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("C_l1_stage", stage, 0);
    applyStimulus(0, 0, 0, 0, 3'b111, 0);
    checkOutput("C_l1_wait", stage, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("C_l2_stage", stage, 1);
    checkOutput("C_rd0", conv_din, modelBits(0));
    for (int k = 1; k < 20; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("C_cleared", conv_din, modelBits(k));
    end
    checkOutput("C_noerr", err, 0);
    applyStimulus(0, 3'b101, 3'b111, 0, 0, 0);
    checkOutput("C_mix_err", err, 1);
    checkOutput("C_mix_fcvalid", fc_valid, 0);
    expErr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      case ($urandom % 3)
        0: v = 3'b000;
        1: v = 3'b111;
        default: v = 3'($urandom_range(1, 6));
      endcase
      r = 3'($urandom);
      applyStimulus(0, v, r, 0, 0, 0);
      checkOutput("C_fcvalid", fc_valid, (v == 3'b111));
      if (v == 3'b111) checkOutput("C_fcdin", fc_din, majority(r));
      checkOutput("C_err", err, expErr);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bnn_fmap_sequencer.md
# bnn_fmap_sequencer

Parametrised layer sequencer for the binary CNN datapath. It feeds CH parallel binary convolution engines through two convolution layers and buffers layer-1 outputs in per-channel bit maps. It reads those maps back for layer 2 and merges layer-2 channel outputs by majority vote into a single serial bit stream for the fully-connected stage. It sits between the pixel source, the conv engines and the FC engine, and owns the top-level inference FSM.

## Interface
- CH, 3, number of parallel conv channels (1..8)
- FMAP_BITS, 676, bits stored per channel feature map
- PIX_W, 8, input pixel width
- THRESH, 127, binarisation threshold: pixel bit = (pic_din > THRESH)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin inference; sampled only in IDLE
- pic_din  in  PIX_W  unsigned pixel for layer 1
- conv_result  in  CH  per-channel conv output bit
- conv_result_valid  in  CH  per-channel output strobe
- conv_rd  in  1  layer-2 engines consume one buffered bit (all channels in lockstep)
- conv_done  in  CH  per-channel layer-complete pulse
- fc_done  in  1  FC engine finished
- conv_din  out  CH  per-channel input bit
- conv_start  out  CH  per-channel layer start pulse
- stage  out  1  0 = layer 1, 1 = layer 2 and later
- fc_din  out  1  majority bit to FC
- fc_valid  out  1  fc_din strobe
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle end-of-inference pulse
- err  out  1  sticky error flag; cleared only on start accepted or reset

## Operation
- FSM states: IDLE, L1, L2, FCW, FIN.
  - IDLE -> L1 on start.
  - L1 -> L2 when done_seen == all ones.
  - L2 -> FCW when done_seen == all ones.
  - FCW -> FIN on fc_done.
  - FIN -> IDLE unconditionally.
- done_seen[CH] latches conv_done bits independently, since pulses may arrive on different cycles. It clears on entry to L1 and on entry to L2.
- Accepting start clears err, wr_ptr[i], rd_ptr and done_seen.
- L1:
  - conv_din[i] = (pic_din > THRESH) for all i, combinational.
  - On conv_result_valid[i], write buf_i[wr_ptr[i]] = conv_result[i] and increment wr_ptr[i].
  - A valid when wr_ptr[i] == FMAP_BITS drops the write and sets err.
- L2:
  - conv_din[i] = buf_i[rd_ptr], combinational from the registered rd_ptr.
  - conv_rd increments rd_ptr.
  - conv_rd at rd_ptr == FMAP_BITS-1 holds rd_ptr and sets err.
  - Buffers are read-only in L2.
  - Merge rule:
    - If all conv_result_valid bits are 1: fc_din = (popcount(conv_result) > CH/2) and fc_valid = 1, both registered. Ties with even CH give 0.
    - If the valid bits are mixed (not all 0 and not all 1): err is set and fc_valid stays 0.
- conv_start[i] is asserted for every i, for exactly the first cycle the FSM is in L1, and for exactly the first cycle it is in L2.
- stage = 1 in L2, FCW and FIN; 0 otherwise. busy = (state != IDLE).
- start outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; all pointers 0; buffers all 0.
  - conv_start, fc_din, fc_valid, done, err = 0; done_seen = 0.
  - conv_din = (pic_din > THRESH), since it is combinational in IDLE/L1.
- start at cycle t (in IDLE): state = L1 and conv_start = all ones at t+1; conv_start = 0 at t+2.
- The buffer write is visible to the L2 read path the cycle after the valid strobe.
- Merge latency is 1 cycle: all-valid at cycle t gives fc_valid and fc_din at t+1.
- A conv_done arriving in the same cycle as the last conv_result_valid is legal; both are processed.
- The final done_seen bit latches at t; the state changes at t+1.
- fc_done at t: FIN at t+1 with done = 1; IDLE at t+2.
- Asynchronous reset mid-inference returns every output to its reset value immediately. There is no resume.

## Test plan
- Reset then idle: busy = 0, err = 0, stage = 0; pic_din = 200 gives conv_din = 3'b111; pic_din = 127 gives 3'b000.
- Full inference, CH = 3:
  - Write alternating 1010… in L1; conv_done pulses arrive on channels 2, 0, 1 on separate cycles, and the FSM enters L2 only after the third.
  - conv_start pulses once per layer.
  - Readback bits match what was written, in order.
- Majority: in L2 with all valid, results 3'b011 -> fc_din = 1, fc_valid one cycle later; 3'b100 -> fc_din = 0; valid 3'b101 -> err = 1, no fc_valid.
- Overflow: 677 valids on channel 0 -> err = 1, first 676 bits intact; 676 conv_rd pulses in L2 -> rd_ptr holds at 675, err = 1.
- Completion and reset: fc_done in FCW -> done high exactly 1 cycle, then IDLE. A new start clears err. rstn low during L2 -> state IDLE, buffers 0.
